ysyx_23060191_dmem_resp: RTL

//   Data-memory responder: target side of the LSU load/store request channel.

---
 rtl/ysyx_23060191_dmem_resp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060191_dmem_resp.sv
// Data-memory responder: accepts one LSU load/store at a time, waits a
// programmable number of cycles, commits the access to internal word storage
// and returns a registered response held until the LSU consumes it.
module ysyx_23060191_dmem_resp #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [30:0] DEPTH_L   = 31'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [29:0] lat_word;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             commit;
  logic             unused_addr_bits;

  // Byte offset within the word is irrelevant for word accesses.
  assign unused_addr_bits = ^req_addr[1:0];

  // Range test works on word addresses so the upper bound can never wrap.
  assign word_off = lat_word - BASE_WORD;
  assign in_range = (lat_word >= BASE_WORD) && ({1'b0, word_off} < DEPTH_L);
  assign idx      = word_off[IDX_W-1:0];
  assign commit   = (state == WAIT) && (cnt == 4'd0);

  // Request/response handshake FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_word   <= 30'd0;
      lat_wdata  <= 32'd0;
      lat_wstrb  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_word  <= req_addr[31:2];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            cnt       <= 4'(LATENCY);
            state     <= WAIT;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !lat_we) ? mem[idx] : 32'd0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane store into storage on the commit edge; storage survives reset.
  always_ff @(posedge clk) begin
    if (commit && lat_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_wstrb[i]) begin
          mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
